// File: rtl/button_pkg.sv
// Shared encodings for the button event logic: event codes and FSM states.
package button_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } state_t;

endpackage

// File: rtl/button_events.sv
// Turns a debounced button level into PRESS/RELEASE/LONG/REPEAT events,
// held in a one-deep register with ready handshake and sticky overflow.
module button_events
    import button_pkg::*;
#(
    parameter int unsigned LONG_LIMIT   = 12000000,
    parameter int unsigned REPEAT_LIMIT = 1200000,
    parameter int unsigned COUNT_SIZE   = 24,
    parameter logic        ACTIVE_LOW   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       pressed,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       overflow,
    input  logic       clr_overflow
);

    localparam logic [COUNT_SIZE-1:0] LONG_TERM = COUNT_SIZE'(LONG_LIMIT - 1);
    localparam logic [COUNT_SIZE-1:0] REP_TERM  =
        COUNT_SIZE'((REPEAT_LIMIT == 0) ? 0 : REPEAT_LIMIT - 1);

    logic                  act;
    state_t                state, state_next;
    logic [COUNT_SIZE-1:0] cnt, cnt_next;
    logic                  gen_valid;
    evt_code_t             gen_code;
    evt_code_t             code_q;
    logic                  load, drop;

    assign act      = btn_in ^ ACTIVE_LOW;
    assign evt_code = code_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pressed <= act;
        end
    end

    // Terminal compare is checked before the increment, so cnt never wraps.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        gen_valid  = 1'b0;
        gen_code   = EVT_PRESS;
        case (state)
            ST_IDLE: begin
                if (act) begin
                    state_next = ST_DOWN;
                    cnt_next   = '0;
                    gen_valid  = 1'b1;
                    gen_code   = EVT_PRESS;
                end
            end
            ST_DOWN: begin
                if (!act) begin
                    state_next = ST_IDLE;
                    gen_valid  = 1'b1;
                    gen_code   = EVT_RELEASE;
                end else if (cnt == LONG_TERM) begin
                    state_next = ST_HELD;
                    cnt_next   = '0;
                    gen_valid  = 1'b1;
                    gen_code   = EVT_LONG;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!act) begin
                    state_next = ST_IDLE;
                    gen_valid  = 1'b1;
                    gen_code   = EVT_RELEASE;
                end else if (REPEAT_LIMIT != 0) begin
                    if (cnt == REP_TERM) begin
                        cnt_next  = '0;
                        gen_valid = 1'b1;
                        gen_code  = EVT_REPEAT;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A full register still accepts a new event in the cycle it is consumed.
    assign load = gen_valid && (!evt_valid || evt_ready);
    assign drop = gen_valid && evt_valid && !evt_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid <= 1'b0;
            code_q    <= EVT_PRESS;
            overflow  <= 1'b0;
        end else begin
            if (load) begin
                evt_valid <= 1'b1;
                code_q    <= gen_code;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with LONG_LIMIT=8, REPEAT_LIMIT=3, plus
// an ACTIVE_LOW instance.
module tb_button_events;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_in = 1'b0;
    logic       pressed, evt_valid, overflow;
    logic [1:0] evt_code;
    logic       evt_ready = 1'b1;
    logic       clr_overflow = 1'b0;

    logic       btn_l = 1'b1;
    logic       pressed_l, evt_valid_l, overflow_l;
    logic [1:0] evt_code_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_events #(
        .LONG_LIMIT(8), .REPEAT_LIMIT(3), .COUNT_SIZE(4), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .pressed(pressed),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    button_events #(
        .LONG_LIMIT(8), .REPEAT_LIMIT(3), .COUNT_SIZE(4), .ACTIVE_LOW(1'b1)
    ) dut_l (
        .clk(clk), .reset(reset), .btn_in(btn_l), .pressed(pressed_l),
        .evt_valid(evt_valid_l), .evt_code(evt_code_l), .evt_ready(1'b1),
        .overflow(overflow_l), .clr_overflow(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Valid check always; code only compared when an event is expected.
    task automatic expect_evt(input string tag, input logic v, input logic [1:0] c);
        check({tag, ".valid"}, {31'd0, evt_valid}, {31'd0, v});
        if (v) check({tag, ".code"}, {30'd0, evt_code}, {30'd0, c});
    endtask

    initial begin
        logic       ev;
        logic [1:0] ec;

        #1 reset = 1'b1;
        tick();
        tick();
        check("rst.pressed", {31'd0, pressed}, 32'd0);
        check("rst.valid", {31'd0, evt_valid}, 32'd0);
        check("rst.code", {30'd0, evt_code}, 32'd0);
        check("rst.overflow", {31'd0, overflow}, 32'd0);
        check("rst.pressed_l", {31'd0, pressed_l}, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_l.pressed", {31'd0, pressed_l}, 32'd0);
        check("idle_l.valid", {31'd0, evt_valid_l}, 32'd0);

        // Active-low instance: driving 0 means pressed.
        btn_l = 1'b0;
        tick();
        check("al.pressed", {31'd0, pressed_l}, 32'd1);
        check("al.valid", {31'd0, evt_valid_l}, 32'd1);
        check("al.code", {30'd0, evt_code_l}, 32'd0);
        btn_l = 1'b1;
        tick();
        tick();

        // Short press: high for 4 cycles.
        btn_in = 1'b1;
        tick(); expect_evt("short.n1", 1'b1, 2'd0);
        check("short.pressed", {31'd0, pressed}, 32'd1);
        tick(); expect_evt("short.n2", 1'b0, 2'd0);
        tick(); expect_evt("short.n3", 1'b0, 2'd0);
        tick(); expect_evt("short.n4", 1'b0, 2'd0);
        btn_in = 1'b0;
        tick(); expect_evt("short.n5", 1'b1, 2'd1);
        tick(); expect_evt("short.n6", 1'b0, 2'd0);

        // Long hold for 20 cycles.
        btn_in = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            tick();
            case (n)
                1:          begin ev = 1'b1; ec = 2'd0; end
                9:          begin ev = 1'b1; ec = 2'd2; end
                12, 15, 18: begin ev = 1'b1; ec = 2'd3; end
                21:         begin ev = 1'b1; ec = 2'd1; end
                default:    begin ev = 1'b0; ec = 2'd0; end
            endcase
            expect_evt($sformatf("long.n%0d", n), ev, ec);
            if (n == 20) btn_in = 1'b0;
        end

        // Consumer stalled: RELEASE dropped while clear is requested in the same cycle.
        evt_ready = 1'b0;
        btn_in = 1'b1;
        tick(); expect_evt("ovf.n1", 1'b1, 2'd0);
        btn_in = 1'b0;
        clr_overflow = 1'b1;
        tick(); expect_evt("ovf.n2", 1'b1, 2'd0);
        check("ovf.set_wins", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b0;
        tick(); expect_evt("ovf.n3", 1'b1, 2'd0);
        check("ovf.sticky", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        tick();
        check("ovf.cleared", {31'd0, overflow}, 32'd0);
        clr_overflow = 1'b0;
        evt_ready = 1'b1;
        tick(); expect_evt("ovf.drain", 1'b0, 2'd0);

        // LONG generated in the same cycle the held PRESS is consumed.
        evt_ready = 1'b0;
        btn_in = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            expect_evt($sformatf("cons.n%0d", n), 1'b1, 2'd0);
        end
        evt_ready = 1'b1;
        tick(); expect_evt("cons.long", 1'b1, 2'd2);
        check("cons.no_ovf", {31'd0, overflow}, 32'd0);
        btn_in = 1'b0;
        tick(); expect_evt("cons.release", 1'b1, 2'd1);
        tick(); expect_evt("cons.drain", 1'b0, 2'd0);

        // Asynchronous reset in HELD, then press seen again with button still down.
        btn_in = 1'b1;
        for (int n = 1; n <= 12; n++) tick();
        expect_evt("ares.pre", 1'b1, 2'd3);
        #2 reset = 1'b1;
        #1;
        check("ares.pressed", {31'd0, pressed}, 32'd0);
        check("ares.valid", {31'd0, evt_valid}, 32'd0);
        check("ares.code", {30'd0, evt_code}, 32'd0);
        check("ares.overflow", {31'd0, overflow}, 32'd0);
        tick();
        reset = 1'b0;
        tick(); expect_evt("ares.press", 1'b1, 2'd0);
        check("ares.pressed2", {31'd0, pressed}, 32'd1);
        tick(); expect_evt("ares.after", 1'b0, 2'd0);
        btn_in = 1'b0;
        tick(); expect_evt("ares.release", 1'b1, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 Parameter LONG_LIMIT, default 12000000, hold cycles after press before a LONG event (1 s at 12 MHz); SHALL be >= 2.
REQ-002 Parameter REPEAT_LIMIT, default 1200000, cycles between REPEAT events while held (100 ms at 12 MHz); 0 disables REPEAT.
REQ-003 Parameter COUNT_SIZE, default 24, counter width; SHALL hold max(LONG_LIMIT, REPEAT_LIMIT).
REQ-004 Parameter ACTIVE_LOW, default 1'b0, 1 = btn_in low means pressed.
REQ-005 clk  input  1  single clock; all state on posedge clk.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 btn_in  input  1  debounced button level (debounce block output), synchronous to clk.
REQ-008 pressed  output  1  registered, normalised pressed level.
REQ-009 evt_valid  output  1  event holding register occupied.
REQ-010 evt_code  output  2  event code: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
REQ-011 evt_ready  input  1  consumer accepts event when evt_valid && evt_ready.
REQ-012 overflow  output  1  sticky: an event was dropped.
REQ-013 clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-014 act = btn_in XOR ACTIVE_LOW; pressed SHALL equal act registered by one cycle.
REQ-015 FSM states IDLE, DOWN, HELD; counter cnt of COUNT_SIZE bits.
REQ-016 IDLE: act=1 -> DOWN, cnt<=0, generate PRESS; else stay.
REQ-017 DOWN: act=0 -> IDLE, generate RELEASE; else if cnt==LONG_LIMIT-1 -> HELD, cnt<=0, generate LONG; else cnt<=cnt+1.
REQ-018 HELD: act=0 -> IDLE, generate RELEASE; else if REPEAT_LIMIT!=0 and cnt==REPEAT_LIMIT-1 -> generate REPEAT, cnt<=0; else cnt<=cnt+1 (REPEAT_LIMIT=0: cnt holds).
REQ-019 Release during DOWN SHALL produce no LONG; exactly one event generated per cycle at most.
REQ-020 Latency: event generated on the edge where act is sampled SHALL appear as evt_valid=1 with its code in the next cycle.
REQ-021 evt_valid/evt_code SHALL stay stable until the cycle with evt_ready=1; evt_valid then drops unless a new event loads in that same cycle.
REQ-022 New event while holding empty, or full with evt_ready=1: load it, evt_valid=1 (no bubble, no drop).
REQ-023 New event while full and evt_ready=0: drop new event, keep held one, set overflow next cycle.
REQ-024 overflow clears only by reset or clr_overflow=1; set in same cycle as clear SHALL win (overflow stays 1).
REQ-025 evt_ready while evt_valid=0 SHALL have no effect.
REQ-026 cnt SHALL never wrap: terminal compare precedes increment.

Reset
REQ-027 reset=1 SHALL immediately force FSM IDLE, cnt=0, pressed=0, evt_valid=0, evt_code=0, overflow=0, independent of clk.
REQ-028 Button active at reset release: first sampled act=1 SHALL generate PRESS normally; reset mid-hold SHALL discard pending event with no RELEASE.

Structure
REQ-029 Event codes and FSM state encodings SHALL live in shared package/include button_pkg; parameters stay local.
REQ-030 Single flat module, no sub-module; instantiated directly downstream of the debouncer.

Verification (LONG_LIMIT=8, REPEAT_LIMIT=3, evt_ready=1 unless stated)
REQ-031 Short press: act high 4 cycles -> PRESS one cycle after rise, RELEASE one cycle after fall, no LONG.
REQ-032 Long hold 20 cycles -> PRESS, LONG 8 cycles after PRESS, REPEAT every 3 cycles thereafter, RELEASE at end.
REQ-033 evt_ready=0 through press+release -> PRESS held, RELEASE dropped, overflow=1; clr_overflow pulse -> overflow=0.
REQ-034 evt_ready=1 in same cycle a LONG is generated with PRESS held -> PRESS consumed, LONG valid next cycle, overflow stays 0.
REQ-035 ACTIVE_LOW=1, btn_in driven 0 -> pressed=1, PRESS event.
REQ-036 Assert reset mid-HELD asynchronously -> all outputs 0 before next clk edge; after release with btn_in still active, PRESS produced.
